dijkstra_ci_frontend: RTL and testbench

// Next-generation Nios II custom-instruction + Avalon-MM slave front end for the Dijkstra accelerator.

---
 rtl/dijkstra_ci_frontend.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dijkstra_ci_frontend.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_ci_frontend.sv
// Nios II custom-instruction and Avalon-MM slave front end for the Dijkstra core.
// One edge cache is shared between CI edge ops, slave (DMA) edge accesses and
// the running core. The front end sequences the core, aborts a run that
// exceeds TIMEOUT_CYCLES and exposes status/IRQ control registers.
module dijkstra_ci_frontend #(
   parameter int INDEX_WIDTH    = 10,
   parameter int VALUE_WIDTH    = 32,
   parameter int NODE_ADDR_BITS = 7,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clock,
   input  logic                   reset,
   // Custom-instruction port
   input  logic                   start,
   input  logic                   clock_enable,
   input  logic [3:0]             select_n,
   input  logic [31:0]            dataa,
   input  logic [31:0]            datab,
   output logic [31:0]            result,
   output logic                   ready,
   // Avalon-MM slave
   input  logic [15:0]            slave_address,
   input  logic                   slave_read,
   input  logic                   slave_write,
   input  logic [31:0]            slave_writedata,
   output logic [31:0]            slave_readdata,
   output logic                   slave_waitrequest,
   output logic                   interrupt_sender_irq,
   // Edge cache
   output logic [INDEX_WIDTH-1:0] ec_from,
   output logic [INDEX_WIDTH-1:0] ec_to,
   output logic                   ec_read,
   output logic                   ec_write,
   output logic [VALUE_WIDTH-1:0] ec_write_data,
   input  logic [VALUE_WIDTH-1:0] ec_read_data,
   input  logic                   ec_ready,
   // Dijkstra core
   output logic                   dj_start,
   output logic                   dj_enable,
   output logic [31:0]            dj_dataa,
   output logic [31:0]            dj_datab,
   input  logic                   dj_ec_query,
   input  logic [INDEX_WIDTH-1:0] dj_ec_from,
   input  logic [INDEX_WIDTH-1:0] dj_ec_to,
   input  logic                   dj_ready,
   input  logic [31:0]            dj_distance,
   output logic [INDEX_WIDTH-1:0] dj_pv_addr,
   input  logic [INDEX_WIDTH-1:0] dj_pv_data
);

   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0]  OP_WR_EDGE   = 4'd0;
   localparam logic [3:0]  OP_RD_EDGE   = 4'd1;
   localparam logic [3:0]  OP_RUN       = 4'd2;
   localparam logic [3:0]  OP_RD_PREV   = 4'd3;
   localparam logic [3:0]  OP_RD_STATUS = 4'd4;

   localparam logic [15:0] CSR_STATUS   = 16'h8000;
   localparam logic [15:0] CSR_IRQ_EN   = 16'h8001;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SLV,
      S_CI_EC,
      S_RUN,
      S_DONE
   } state_t;

   state_t                    state;
   state_t                    next_state;

   logic [3:0]                op_q;
   logic [31:0]               dataa_q;
   logic [31:0]               datab_q;
   logic [NODE_ADDR_BITS-1:0] slv_from_q;
   logic [NODE_ADDR_BITS-1:0] slv_to_q;
   logic [VALUE_WIDTH-1:0]    slv_wdata_q;
   logic                      slv_write_q;
   logic [TIMER_WIDTH-1:0]    timer_q;
   logic                      irq_en_q;
   logic                      irq_pending_q;
   logic                      timeout_q;

   logic                      slave_access;
   logic                      csr_wr_en;
   logic                      busy;
   logic                      timer_expired;
   logic [31:0]               status_word;
   logic [31:0]               csr_rdata;

   assign slave_access         = slave_read | slave_write;
   assign busy                 = (state != S_IDLE);
   assign timer_expired        = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES));
   assign status_word          = {29'b0, timeout_q, busy, irq_pending_q};
   assign csr_rdata            = (slave_address == CSR_STATUS) ? status_word :
                                 (slave_address == CSR_IRQ_EN) ? {31'b0, irq_en_q} : 32'h0;
   assign interrupt_sender_irq = irq_pending_q & irq_en_q;
   assign dj_enable            = (state == S_RUN);
   assign dj_dataa             = dataa_q;
   assign dj_datab             = datab_q;
   assign dj_pv_addr           = dataa_q[INDEX_WIDTH-1:0];

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples the pre-edge value of every other flop, as hardware does.
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state, edge-cache mux, slave handshake and CSR decode.
   always_comb begin
      // NOTE: every output of this block gets a default first; any path that
      // left one unassigned would infer a latch.
      next_state        = state;
      ec_from           = '0;
      ec_to             = '0;
      ec_read           = 1'b0;
      ec_write          = 1'b0;
      ec_write_data     = '0;
      slave_waitrequest = 1'b0;
      slave_readdata    = 32'h0;
      csr_wr_en         = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               // The CI always wins; a concurrent slave access waits its turn.
               slave_waitrequest = slave_access;
               case (select_n)
                  OP_WR_EDGE, OP_RD_EDGE: next_state = S_CI_EC;
                  OP_RUN:                 next_state = S_RUN;
                  default:                next_state = S_DONE;
               endcase
            end else if (slave_access && slave_address[15]) begin
               // Control registers answer with zero wait states while idle.
               slave_readdata = csr_rdata;
               csr_wr_en      = slave_write;
            end else if (slave_access) begin
               slave_waitrequest = 1'b1;
               next_state        = S_SLV;
            end
         end

         S_SLV: begin
            ec_from           = INDEX_WIDTH'(slv_from_q);
            ec_to             = INDEX_WIDTH'(slv_to_q);
            ec_read           = ~slv_write_q;
            ec_write          = slv_write_q;
            ec_write_data     = slv_wdata_q;
            // The transfer completes in the cycle the cache reports done.
            slave_waitrequest = ~ec_ready;
            if (ec_ready) begin
               slave_readdata = 32'(ec_read_data);
               next_state     = S_IDLE;
            end
         end

         S_CI_EC: begin
            ec_from           = dataa_q[INDEX_WIDTH-1:0];
            ec_to             = dataa_q[16 +: INDEX_WIDTH];
            ec_read           = (op_q == OP_RD_EDGE);
            ec_write          = (op_q == OP_WR_EDGE);
            ec_write_data     = datab_q[VALUE_WIDTH-1:0];
            slave_waitrequest = slave_access;
            if (ec_ready) next_state = S_DONE;
         end

         S_RUN: begin
            // The core owns the cache for the whole run.
            ec_from           = dj_ec_from;
            ec_to             = dj_ec_to;
            ec_read           = dj_ec_query;
            slave_waitrequest = slave_access;
            if (dj_ready || timer_expired) next_state = S_DONE;
         end

         S_DONE: begin
            slave_waitrequest = slave_access;
            if (clock_enable) next_state = S_IDLE;
         end

         default: next_state = S_IDLE;
      endcase
   end

   // Operand latches, run timer, CI result/ready and status/IRQ registers.
   always_ff @(posedge clock) begin
      // NOTE: only control and status flops need a reset value; operand and
      // address latches are reset too so a fresh run never sees stale data.
      if (reset) begin
         result        <= 32'h0;
         ready         <= 1'b0;
         dj_start      <= 1'b0;
         op_q          <= 4'd0;
         dataa_q       <= 32'h0;
         datab_q       <= 32'h0;
         slv_from_q    <= '0;
         slv_to_q      <= '0;
         slv_wdata_q   <= '0;
         slv_write_q   <= 1'b0;
         timer_q       <= '0;
         irq_en_q      <= 1'b0;
         irq_pending_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         ready    <= 1'b0;
         dj_start <= 1'b0;

         if (csr_wr_en) begin
            if (slave_address == CSR_STATUS && slave_writedata[0]) begin
               irq_pending_q <= 1'b0;
               timeout_q     <= 1'b0;
            end
            if (slave_address == CSR_IRQ_EN) irq_en_q <= slave_writedata[0];
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q     <= select_n;
                  dataa_q  <= dataa;
                  datab_q  <= datab;
                  timer_q  <= '0;
                  dj_start <= (select_n == OP_RUN);
               end else if (slave_access && !slave_address[15]) begin
                  slv_from_q  <= slave_address[NODE_ADDR_BITS-1:0];
                  slv_to_q    <= slave_address[2*NODE_ADDR_BITS-1:NODE_ADDR_BITS];
                  slv_wdata_q <= slave_writedata[VALUE_WIDTH-1:0];
                  slv_write_q <= slave_write;
               end
            end

            S_CI_EC: begin
               if (ec_ready)
                  result <= (op_q == OP_RD_EDGE) ? 32'(ec_read_data) : 32'h0000BEEF;
            end

            S_RUN: begin
               timer_q <= timer_q + TIMER_WIDTH'(1);
               // A completion in the expiry cycle is reported as a completion.
               // Setting pending here also overrides any clear in the same cycle.
               if (dj_ready) begin
                  result        <= dj_distance;
                  irq_pending_q <= 1'b1;
               end else if (timer_expired) begin
                  result        <= 32'hFFFFFFFF;
                  timeout_q     <= 1'b1;
                  irq_pending_q <= 1'b1;
               end
            end

            S_DONE: begin
               if (clock_enable) begin
                  ready <= 1'b1;
                  case (op_q)
                     OP_WR_EDGE, OP_RD_EDGE, OP_RUN: ;
                     OP_RD_PREV:   result <= 32'(dj_pv_data);
                     OP_RD_STATUS: result <= status_word;
                     default:      result <= 32'hDEADBEEF;
                  endcase
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dijkstra_ci_frontend.sv
// Self-checking bench for dijkstra_ci_frontend: directed CI and slave
// transactions, an edge-cache model with programmable latency, and a
// scoreboard monitor that checks every CI ready and every slave read ack.
module tb_dijkstra_ci_frontend;

   localparam int IW = 10;
   localparam int VW = 32;
   localparam int T  = 120;   // run timeout, long enough for the 100-cycle run

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          clock_enable;
   logic [3:0]    select_n;
   logic [31:0]   dataa, datab;
   logic [31:0]   result;
   logic          ready;
   logic [15:0]   slave_address;
   logic          slave_read, slave_write;
   logic [31:0]   slave_writedata;
   logic [31:0]   slave_readdata;
   logic          slave_waitrequest;
   logic          interrupt_sender_irq;
   logic [IW-1:0] ec_from, ec_to;
   logic          ec_read, ec_write;
   logic [VW-1:0] ec_write_data;
   logic [VW-1:0] ec_read_data = '0;
   logic          ec_ready = 1'b0;
   logic          dj_start, dj_enable;
   logic [31:0]   dj_dataa, dj_datab;
   logic          dj_ec_query;
   logic [IW-1:0] dj_ec_from, dj_ec_to;
   logic          dj_ready;
   logic [31:0]   dj_distance;
   logic [IW-1:0] dj_pv_addr;
   logic [IW-1:0] dj_pv_data;

   dijkstra_ci_frontend #(
      .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .NODE_ADDR_BITS(7), .TIMEOUT_CYCLES(T)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .clock_enable(clock_enable),
      .select_n(select_n), .dataa(dataa), .datab(datab), .result(result), .ready(ready),
      .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
      .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
      .slave_waitrequest(slave_waitrequest), .interrupt_sender_irq(interrupt_sender_irq),
      .ec_from(ec_from), .ec_to(ec_to), .ec_read(ec_read), .ec_write(ec_write),
      .ec_write_data(ec_write_data), .ec_read_data(ec_read_data), .ec_ready(ec_ready),
      .dj_start(dj_start), .dj_enable(dj_enable), .dj_dataa(dj_dataa), .dj_datab(dj_datab),
      .dj_ec_query(dj_ec_query), .dj_ec_from(dj_ec_from), .dj_ec_to(dj_ec_to),
      .dj_ready(dj_ready), .dj_distance(dj_distance),
      .dj_pv_addr(dj_pv_addr), .dj_pv_data(dj_pv_data)
   );

   always #5 clock = ~clock;

   // Previous-vector memory model: a fixed pattern of the address.
   assign dj_pv_data = dj_pv_addr ^ 10'h155;

   // Edge-cache model: ec_ready arrives ec_delay cycles after the strobe first
   // appears and stays high for one cycle.
   int            ec_delay = 1;
   int            ec_cnt   = 0;
   logic [31:0]   ec_mem [0:1023];
   logic [9:0]    ec_key;
   assign ec_key = {ec_from[4:0], ec_to[4:0]};

   always @(posedge clock) begin
      if (ec_ready) begin
         ec_ready <= 1'b0;
         ec_cnt   <= 0;
      end else if (ec_read || ec_write) begin
         if (ec_cnt + 1 >= ec_delay) begin
            ec_ready <= 1'b1;
            if (ec_write) begin
               ec_mem[ec_key] <= ec_write_data;
               ec_read_data   <= ec_write_data;
            end else begin
               ec_read_data   <= ec_mem[ec_key];
            end
         end else begin
            ec_cnt <= ec_cnt + 1;
         end
      end else begin
         ec_cnt <= 0;
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ci_q [$];
   logic [31:0] rd_q [$];
   time         last_ready_t = 0;
   bit          ready_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compares every CI ready and every completed slave read.
   always @(negedge clock) begin
      if (ready_prev) check("ready_one_cycle", 32'(ready), 32'd0);
      if (ready) begin
         last_ready_t = $time;
         if (ci_q.size() == 0) check("unexpected_ready", 32'(ready), 32'd0);
         else                  check("ci_result", result, ci_q.pop_front());
      end
      if (slave_read && !slave_waitrequest) begin
         if (rd_q.size() == 0) check("unexpected_read_ack", 32'(slave_read), 32'd0);
         else                  check("slave_readdata", slave_readdata, rd_q.pop_front());
      end
      ready_prev = ready;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ci_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit push);
      if (push) ci_q.push_back(exp);
      start    = 1'b1;
      select_n = op;
      dataa    = a;
      datab    = b;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (ready) seen = 1'b1;
      end
      check("ready_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_dj_start();
      int n = 0;
      while (!dj_start && n < 10) begin
         tick();
         n++;
      end
      check("dj_start_seen", 32'(dj_start), 32'd1);
   endtask

   // One Avalon transfer; reports the number of waitrequest cycles seen.
   task automatic slave_access(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rd, output int waits, output time t_done);
      bit done = 1'b0;
      if (!wr) rd_q.push_back(exp_rd);
      slave_address   = addr;
      slave_writedata = wdata;
      slave_write     = wr;
      slave_read      = ~wr;
      waits           = 0;
      t_done          = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clock);
         if (!slave_waitrequest) begin
            done   = 1'b1;
            t_done = $time;
         end else begin
            waits++;
         end
      end
      check("slave_ack_seen", 32'(done), 32'd1);
      tick();
      slave_write = 1'b0;
      slave_read  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_result"},      result,                      32'd0);
      check({tag, "_ready"},       32'(ready),                  32'd0);
      check({tag, "_waitrequest"}, 32'(slave_waitrequest),      32'd0);
      check({tag, "_irq"},         32'(interrupt_sender_irq),   32'd0);
      check({tag, "_ec_read"},     32'(ec_read),                32'd0);
      check({tag, "_ec_write"},    32'(ec_write),               32'd0);
      check({tag, "_dj_start"},    32'(dj_start),               32'd0);
      check({tag, "_dj_enable"},   32'(dj_enable),              32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  waits;
      int  cyc;
      time t_done;

      reset = 1'b1; start = 1'b0; clock_enable = 1'b1; select_n = '0;
      dataa = '0; datab = '0; slave_address = '0; slave_read = 1'b0;
      slave_write = 1'b0; slave_writedata = '0; dj_ec_query = 1'b0;
      dj_ec_from = '0; dj_ec_to = '0; dj_ready = 1'b0; dj_distance = '0;
      repeat (3) tick();
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      // CI edge write then read of (3 -> 5).
      ec_delay = 1;
      ci_issue(4'd0, {16'd5, 16'd3}, 32'd42, 32'h0000BEEF, 1'b1);
      wait_ready(20);
      ci_issue(4'd1, {16'd5, 16'd3}, 32'd0, 32'd42, 1'b1);
      wait_ready(20);

      // Slave edge write 0x0283 = (from 3, to 5); ec_ready 3 cycles after the request.
      ec_delay = 2;
      slave_access(1'b1, 16'h0283, 32'd77, 32'd0, waits, t_done);
      check("slave_wr_waits", 32'(waits), 32'd3);

      // start and slave_read in the same cycle: CI is served first.
      ec_delay = 1;
      fork
         slave_access(1'b0, 16'h0283, 32'd0, 32'd77, waits, t_done);
         ci_issue(4'd1, {16'd5, 16'd3}, 32'd0, 32'd77, 1'b1);
      join
      check("slave_after_ci", 32'(t_done > last_ready_t), 32'd1);
      check("start_beats_slave_waits", 32'(waits), 32'd6);

      // Zero-wait CSR access while idle.
      slave_access(1'b1, 16'h8001, 32'd1, 32'd0, waits, t_done);
      check("csr_wr_zero_wait", 32'(waits), 32'd0);
      slave_access(1'b0, 16'h8001, 32'd0, 32'd1, waits, t_done);
      check("csr_rd_zero_wait", 32'(waits), 32'd0);
      slave_access(1'b0, 16'h8002, 32'd0, 32'd0, waits, t_done);

      // Run: core done 100 cycles into RUN with distance 17, irq enabled.
      ci_issue(4'd2, 32'd0, 32'd0, 32'd17, 1'b1);
      wait_dj_start();
      dj_ec_query = 1'b1; dj_ec_from = 10'd3; dj_ec_to = 10'd5;
      @(negedge clock);
      check("run_ec_read",   32'(ec_read),   32'd1);
      check("run_ec_from",   32'(ec_from),   32'd3);
      check("run_ec_to",     32'(ec_to),     32'd5);
      check("run_dj_enable", 32'(dj_enable), 32'd1);
      tick();
      dj_ec_query = 1'b0;
      repeat (99) tick();
      dj_ready = 1'b1; dj_distance = 32'd17;
      tick();
      dj_ready = 1'b0;
      wait_ready(10);
      check("irq_enabled_run", 32'(interrupt_sender_irq), 32'd1);
      slave_access(1'b0, 16'h8000, 32'd0, 32'd1, waits, t_done);
      slave_access(1'b1, 16'h8000, 32'd1, 32'd0, waits, t_done);
      check("irq_cleared", 32'(interrupt_sender_irq), 32'd0);
      slave_access(1'b0, 16'h8000, 32'd0, 32'd0, waits, t_done);

      // Run with irq disabled: pending sets but irq stays low.
      slave_access(1'b1, 16'h8001, 32'd0, 32'd0, waits, t_done);
      ci_issue(4'd2, 32'd0, 32'd0, 32'd23, 1'b1);
      wait_dj_start();
      repeat (5) tick();
      dj_ready = 1'b1; dj_distance = 32'd23;
      tick();
      dj_ready = 1'b0;
      wait_ready(10);
      check("irq_disabled_run", 32'(interrupt_sender_irq), 32'd0);
      slave_access(1'b0, 16'h8000, 32'd0, 32'd1, waits, t_done);
      slave_access(1'b1, 16'h8000, 32'd1, 32'd0, waits, t_done);

      // Core done in exactly the expiry cycle: completion wins, no timeout.
      ci_issue(4'd2, 32'd0, 32'd0, 32'd5, 1'b1);
      wait_dj_start();
      repeat (T) tick();
      dj_ready = 1'b1; dj_distance = 32'd5;
      tick();
      dj_ready = 1'b0;
      wait_ready(10);
      slave_access(1'b0, 16'h8000, 32'd0, 32'd1, waits, t_done);
      slave_access(1'b1, 16'h8000, 32'd1, 32'd0, waits, t_done);

      // Timeout: core never ready; a CSR read issued during RUN stalls until idle.
      ci_issue(4'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1);
      wait_dj_start();
      cyc = 0;
      fork
         slave_access(1'b0, 16'h8000, 32'd0, 32'd5, waits, t_done);
         begin
            while (!ready && cyc < 400) begin
               tick();
               cyc++;
            end
         end
      join
      check("timeout_latency", 32'(cyc), 32'(T + 2));
      check("csr_stall_in_run", 32'(waits), 32'(T + 2));
      slave_access(1'b1, 16'h8000, 32'd1, 32'd0, waits, t_done);
      slave_access(1'b0, 16'h8000, 32'd0, 32'd0, waits, t_done);

      // DONE-only opcodes: previous vector, status (busy while in DONE), unknown.
      ci_issue(4'd3, 32'h0000_0012, 32'd0, 32'h0000_0147, 1'b1);
      wait_ready(10);
      ci_issue(4'd4, 32'd0, 32'd0, 32'h0000_0002, 1'b1);
      wait_ready(10);
      ci_issue(4'd7, 32'd0, 32'd0, 32'hDEADBEEF, 1'b1);
      wait_ready(10);

      // Reset in RUN: aborts with no ready pulse and clears irq_en.
      slave_access(1'b1, 16'h8001, 32'd1, 32'd0, waits, t_done);
      ci_issue(4'd2, 32'd0, 32'd0, 32'd0, 1'b0);
      wait_dj_start();
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check_reset_outputs("rst_run");
      reset = 1'b0;
      repeat (3) tick();
      slave_access(1'b0, 16'h8001, 32'd0, 32'd0, waits, t_done);

      // Reset in SLV: the edge write is abandoned before the cache completes it.
      ec_delay        = 20;
      slave_address   = 16'h0283;
      slave_writedata = 32'd9;
      slave_write     = 1'b1;
      repeat (3) tick();
      check("slv_ec_write", 32'(ec_write), 32'd1);
      reset       = 1'b1;
      slave_write = 1'b0;
      tick();
      check_reset_outputs("rst_slv");
      reset = 1'b0;
      repeat (2) tick();
      ec_delay = 1;
      slave_access(1'b0, 16'h0283, 32'd0, 32'd77, waits, t_done);

      repeat (3) tick();
      check("ci_queue_drained", 32'(ci_q.size()), 32'd0);
      check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
